serial_adder: RTL



---
 rtl/serial_pkg.sv | 12 +
 rtl/full_adder_bit.sv | 20 ++
 rtl/serial_adder.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder built from two half-adder stages plus an OR.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs;
  logic hc1;
  logic hc2;

  assign hs  = a ^ b;
  assign hc1 = a & b;
  assign s   = hs ^ ci;
  assign hc2 = hs & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per cycle, LSB first,
// with a start/busy/done handshake and a registered sum/cout.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one bit pair per edge, count = bits already processed
  // DONE  | one-cycle done pulse; start here re-launches immediately
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             fa_s;
  logic             fa_co;

  full_adder_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_co;
      work  <= {fa_s, work[WIDTH-1:1]};
      count <= last ? '0 : count + CNT_W'(1);
      // The final bit goes straight into sum so the result is ready with done.
      if (last) begin
        sum  <= {fa_s, work[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end

endmodule
